inst_buffer: RTL and testbench

Instruction buffer between the fetch stage and the decode stage. It accepts one fetched instruction per cycle from the fetch stage's write port (`ib_write_req`/`ib_pc`/`ib_inst`/`ib_exc`) and presents the oldest buffered instruction to decode through a valid/allowin handshake. Its job is to decouple icache return timing from decode stalls. It also discards all contents on a pipeline flush.

---
 rtl/inst_buffer.sv | 65 ++++++
 tb/tb_inst_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO with show-ahead
// head output, a registered-only full flag, and a flush that empties it in one edge.
module inst_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = 67
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          ib_write_req,
  input  logic [31:0]   ib_pc,
  input  logic [31:0]   ib_inst,
  input  logic [2:0]    ib_exc,
  output logic          ib_full,
  input  logic          ds_allowin,
  output logic          ib_to_ds_valid,
  output logic [EW-1:0] ib_to_ds_bus,
  output logic [AW:0]   ib_count
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  // Full comes from the counter alone so the fetch stage's ready logic never
  // sees a combinational path from ds_allowin.
  assign ib_full        = (r_count == (AW+1)'(DEPTH));
  assign ib_to_ds_valid = (r_count != '0);
  assign ib_to_ds_bus   = r_mem[r_rptr];
  assign ib_count       = r_count;

  assign w_push = ib_write_req && !ib_full && !flush;
  assign w_pop  = ib_to_ds_valid && ds_allowin && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      // Storage is left stale; valid is gated by the zeroed count.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {ib_exc, ib_pc, ib_inst};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model in a negedge monitor.
module tb_inst_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        ib_write_req = 1'b0;
  logic [31:0] ib_pc = '0;
  logic [31:0] ib_inst = '0;
  logic [2:0]  ib_exc = '0;
  logic        ds_allowin = 1'b0;
  logic        ib_full;
  logic        ib_to_ds_valid;
  logic [66:0] ib_to_ds_bus;
  logic [4:0]  ib_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [66:0] exp_q [$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ib_write_req(ib_write_req), .ib_pc(ib_pc), .ib_inst(ib_inst), .ib_exc(ib_exc),
    .ib_full(ib_full), .ds_allowin(ds_allowin),
    .ib_to_ds_valid(ib_to_ds_valid), .ib_to_ds_bus(ib_to_ds_bus), .ib_count(ib_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain queue of expected entries, updated once per cycle
  // from the inputs as they will be seen at the next rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      check("rst_full",  67'(ib_full), 67'd0);
      check("rst_valid", 67'(ib_to_ds_valid), 67'd0);
      check("rst_bus",   ib_to_ds_bus, 67'd0);
      check("rst_count", 67'(ib_count), 67'd0);
    end else begin
      int  sz;
      bit  do_pop, do_push;
      sz = exp_q.size();
      check("count", 67'(ib_count), 67'(sz));
      check("valid", 67'(ib_to_ds_valid), 67'(sz != 0));
      check("full",  67'(ib_full), 67'(sz == DEPTH));
      if (sz != 0) check("head_bus", ib_to_ds_bus, exp_q[0]);
      if (flush) exp_q.delete();
      else begin
        do_pop  = (sz != 0) && ds_allowin;
        do_push = ib_write_req && (sz < DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({ib_exc, ib_pc, ib_inst});
      end
    end
  end

  // Drive one cycle's inputs, then move to just after the next rising edge.
  task automatic cyc(input bit wr, input logic [31:0] pc, input logic [2:0] exc,
                     input bit alw, input bit fl);
    ib_write_req = wr;
    ib_pc        = pc;
    ib_inst      = pc ^ 32'h2408_0000;
    ib_exc       = exc;
    ds_allowin   = alw;
    flush        = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit alw);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 3'b000, alw, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(2, 1'b0);
    resetn = 1'b1;
  endtask

  task automatic scen1();
    ib_write_req = 1'b1; ib_pc = 32'hBFC0_0000; ib_inst = 32'h2408_0001; ib_exc = 3'b000;
    ds_allowin = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    ib_write_req = 1'b0;
    @(negedge clk);
    check("s1_bus", ib_to_ds_bus, {3'b000, 32'hBFC0_0000, 32'h2408_0001});
    @(posedge clk); #1;
    idle(1, 1'b1);
    idle(2, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    idle(1, 1'b1);  // allowin while empty has no effect

    scen1();

    // Fill to full, ignored 17th write, single pop, ordered drain.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + 32'(4*i), 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 32'h2000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Prefill 3, then sustained push+pop across the pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h5000 + 32'(4*i), 3'b000, 1'b0, 1'b0);
    for (int i = 3; i < 43; i++) cyc(1'b1, 32'h5000 + 32'(4*i), 3'b000, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Exception flags travel with their own pc.
    cyc(1'b1, 32'h0000_0003, 3'b001, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0000, 3'b100, 1'b0, 1'b0);
    check("s4_exc0", 67'(ib_to_ds_bus[66:64]), 67'(3'b001));
    idle(1, 1'b1);
    check("s4_exc1", 67'(ib_to_ds_bus[66:64]), 67'(3'b100));
    idle(2, 1'b1);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h6000 + 32'(4*i), 3'b010, 1'b0, 1'b0);
    cyc(1'b1, 32'h3000, 3'b000, 1'b1, 1'b1);
    check("s5_count", 67'(ib_count), 67'd0);
    cyc(1'b1, 32'h4000, 3'b000, 1'b0, 1'b0);
    check("s5_alone", 67'(ib_count), 67'd1);
    check("s5_pc", 67'(ib_to_ds_bus[63:32]), 67'(32'h4000));
    idle(3, 1'b1);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      bit wr, alw, fl;
      wr  = !ib_full && ($urandom_range(0, 3) != 0);
      alw = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      cyc(wr, $urandom, 3'($urandom), alw, fl);
    end
    idle(DEPTH + 2, 1'b1);

    // Asynchronous reset between edges with 7 entries held.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h7000 + 32'(4*i), 3'b000, 1'b0, 1'b0);
    ib_write_req = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("s6_valid", 67'(ib_to_ds_valid), 67'd0);
    check("s6_full",  67'(ib_full), 67'd0);
    check("s6_count", 67'(ib_count), 67'd0);
    @(posedge clk); #1;
    idle(1, 1'b0);
    resetn = 1'b1;
    idle(1, 1'b0);
    scen1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
